// File: rtl/aes_cipher_iter_if.sv
// -----------------------------------------------------------------------------
// aes_cipher_iter_if
//   Streaming bus between a block source, the iterative AES encryptor and the
//   ciphertext sink. It carries the input handshake with plaintext and the
//   precomputed key schedule, and the output handshake with the ciphertext.
//
//   Parameter
//     Nk            key length in 32-bit words (4, 6 or 8); sets the key bus width
//
//   Signals
//     in_valid      source -> encryptor   plaintext/keys valid
//     in_ready      encryptor -> source   block can be accepted
//     plainText     source -> encryptor   128-bit block, byte 0 in [127:120]
//     keys          source -> encryptor   round key i = keys[128*i +: 128]
//     out_valid     encryptor -> sink     encryptedText valid
//     out_ready     sink -> encryptor     sink accepts the result
//     encryptedText encryptor -> sink     128-bit ciphertext
//
//   Modports
//     master        block source / sink side (testbench, upstream logic)
//     slave         encryptor side
// -----------------------------------------------------------------------------
interface aes_cipher_iter_if #(
    parameter int Nk = 4
);
    localparam int Nr = Nk + 6;
    localparam int KW = 128 * (Nr + 1);

    logic            in_valid;
    logic            in_ready;
    logic [127:0]    plainText;
    logic [0:KW-1]   keys;
    logic            out_valid;
    logic            out_ready;
    logic [127:0]    encryptedText;

    modport master (
        output in_valid,
        output plainText,
        output keys,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  encryptedText
    );

    modport slave (
        input  in_valid,
        input  plainText,
        input  keys,
        input  out_ready,
        output in_ready,
        output out_valid,
        output encryptedText
    );
endinterface

// File: rtl/aes_cipher_iter.sv
// -----------------------------------------------------------------------------
// aes_cipher_iter
//   Iterative AES-128/192/256 encryptor. One cipher round is computed per clock
//   from a precomputed key schedule; valid/ready handshakes on both sides.
//   The SubBytes, ShiftRows, MixColumns and AddRoundKey steps are built in.
//
//   Parameters
//     Nk          key length in 32-bit words: 4, 6 or 8 (anything else stops
//                 elaboration). Round count Nr = Nk+6 and key bus width
//                 KW = 128*(Nr+1) are derived and cannot be overridden.
//
//   Ports
//     clk         clock, rising edge
//     reset       asynchronous, active-high
//     clear       synchronous abort back to IDLE (wins over every transition)
//     bus         aes_cipher_iter_if.slave: in_valid/in_ready/plainText/keys,
//                 out_valid/out_ready/encryptedText (registered)
//     busy        high while in ROUND or FINAL
//     round_idx   current round counter (debug)
//
//   Build option
//     AES_ITER_KEY_LATCH_EN  when defined, the key schedule is captured into an
//                 internal register on the accept cycle so the source may change
//                 keys right after the handshake. When undefined, the live keys
//                 bus is read every round and must stay stable from accept until
//                 out_valid. Timing and handshake are identical in both builds.
// -----------------------------------------------------------------------------
module aes_cipher_iter #(
    parameter int Nk = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    aes_cipher_iter_if.slave bus,
    output logic             busy,
    output logic [3:0]       round_idx
);
    localparam int Nr = Nk + 6;
    localparam int KW = 128 * (Nr + 1);

    if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_bad_nk
        $error("aes_cipher_iter: Nk must be 4, 6 or 8");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Forward S-box, entry 0 leftmost.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]   state_q, state_d;
    logic [127:0] blk_q, blk_d;          // running cipher state
    logic [3:0]   round_idx_q, round_idx_d;
    logic [127:0] ct_q, ct_d;            // ciphertext output register
    logic         out_valid_q, out_valid_d;

    // ------------------------------------------------------------------------
    // Key schedule source
    // ------------------------------------------------------------------------
    logic [0:KW-1] key_src;

`ifdef AES_ITER_KEY_LATCH_EN
    logic          key_load;
    logic [0:KW-1] key_q;

    // Same condition as the IDLE accept in the FSM, including clear priority.
    assign key_load = (state_q == S_IDLE) && bus.in_valid && !clear;

    // Pure data register: its contents only matter after a load, so it
    // carries no reset.
    always_ff @(posedge clk) begin
        if (key_load) begin
            key_q <= bus.keys;
        end
    end

    assign key_src = key_q;
`else
    assign key_src = bus.keys;
`endif

    // Split the schedule into round keys; rk[i] is keys[128*i +: 128].
    logic [127:0] rk [0:Nr];

    for (genvar gi = 0; gi <= Nr; gi++) begin : g_rk
        assign rk[gi] = key_src[128*gi +: 128];
    end

    // The key for the current step is always indexed by round_idx: rounds
    // 1..Nr-1 in ROUND, and Nr in FINAL (round_idx has advanced to Nr).
    logic [127:0] rk_cur;
    assign rk_cur = rk[round_idx_q];

    // ------------------------------------------------------------------------
    // Round datapath
    // ------------------------------------------------------------------------
    logic [127:0] sub_w;     // SubBytes(blk_q)
    logic [127:0] shr_w;     // ShiftRows(SubBytes(blk_q))
    logic [127:0] mix_w;     // MixColumns(ShiftRows(SubBytes(blk_q)))
    logic [127:0] round_w;   // full middle round
    logic [127:0] final_w;   // last round, no MixColumns
    logic [127:0] init_w;    // initial AddRoundKey on the live bus

    for (genvar gi = 0; gi < 16; gi++) begin : g_sub
        assign sub_w[127-8*gi -: 8] = SBOX[blk_q[127-8*gi -: 8]];
    end

    // Byte k sits at row k%4, column k/4. Row r rotates left by r columns:
    // out(r,c) = in(r,(c+r)%4).
    for (genvar gi = 0; gi < 16; gi++) begin : g_shift
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
        assign shr_w[127-8*gi -: 8] = sub_w[127-8*SRC -: 8];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = shr_w[127-32*gi -: 8];
        assign a1 = shr_w[119-32*gi -: 8];
        assign a2 = shr_w[111-32*gi -: 8];
        assign a3 = shr_w[103-32*gi -: 8];
        assign mix_w[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mix_w[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mix_w[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mix_w[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    assign round_w = mix_w ^ rk_cur;
    assign final_w = shr_w ^ rk_cur;
    // Round key 0 always comes from the live bus: in the latched build the
    // key register is only being loaded on this same edge.
    assign init_w  = bus.plainText ^ bus.keys[0 +: 128];

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        round_idx_d = round_idx_q;
        ct_d        = ct_q;
        out_valid_d = out_valid_q;

        if (clear) begin
            // Abort: the in-flight block is dropped, ciphertext keeps its value.
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            round_idx_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        blk_d       = init_w;
                        round_idx_d = 4'd1;
                        state_d     = S_ROUND;
                    end
                end
                S_ROUND: begin
                    blk_d       = round_w;
                    round_idx_d = round_idx_q + 4'd1;
                    if (round_idx_q == 4'(Nr - 1)) begin
                        state_d = S_FINAL;
                    end
                end
                S_FINAL: begin
                    ct_d        = final_w;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        round_idx_d = 4'd0;
                        state_d     = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            blk_q       <= '0;
            round_idx_q <= 4'd0;
            ct_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            round_idx_q <= round_idx_d;
            ct_q        <= ct_d;
            out_valid_q <= out_valid_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.in_ready      = (state_q == S_IDLE);
    assign bus.out_valid     = out_valid_q;
    assign bus.encryptedText = ct_q;
    assign busy              = (state_q == S_ROUND) || (state_q == S_FINAL);
    assign round_idx         = round_idx_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_cipher_iter
//   Directed known-answer bench for aes_cipher_iter with three instances
//   (Nk = 4, 6, 8). Key schedules are expanded here from the cipher keys;
//   expected ciphertexts are the published AES reference vectors.
// -----------------------------------------------------------------------------
module tb_aes_cipher_iter;
    localparam logic [127:0] PT1    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY1   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY2   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear4, clear6, clear8;
    logic       busy4, busy6, busy8;
    logic [3:0] ri4, ri6, ri8;
    int         checks = 0;
    int         fails  = 0;
    int         cyc    = 0;

    logic [0:1407] ks4_1, ks4_2;
    logic [0:1663] ks6;
    logic [0:1919] ks8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_cipher_iter_if #(.Nk(4)) if4 ();
    aes_cipher_iter_if #(.Nk(6)) if6 ();
    aes_cipher_iter_if #(.Nk(8)) if8 ();

    aes_cipher_iter #(.Nk(4)) u4 (.clk(clk), .reset(reset), .clear(clear4), .bus(if4), .busy(busy4), .round_idx(ri4));
    aes_cipher_iter #(.Nk(6)) u6 (.clk(clk), .reset(reset), .clear(clear6), .bus(if6), .busy(busy6), .round_idx(ri6));
    aes_cipher_iter #(.Nk(8)) u8 (.clk(clk), .reset(reset), .clear(clear8), .bus(if8), .busy(busy8), .round_idx(ri8));

    // ---------------- key expansion (stimulus generation) ----------------
    function automatic logic [7:0] gx(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = gx(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse, then affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] q = 8'h01;
        for (int i = 0; i < 254; i++) q = gmul(q, x);
        return q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_calc(w[31:24]), sbox_calc(w[23:16]), sbox_calc(w[15:8]), sbox_calc(w[7:0])};
    endfunction

    function automatic logic [0:1919] expand(input int nk, input logic [255:0] key);
        logic [31:0]   w [0:59];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [0:1919] r;
        int            total;
        r     = '0;
        rcon  = 8'h01;
        total = 4 * (nk + 7);
        for (int i = 0; i < total; i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = gx(rcon);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            r[32*i +: 32] = w[i];
        end
        return r;
    endfunction

    // Drive one block into the Nk=4 instance and wait for its result.
    task automatic run4(input logic [127:0] pt, input logic [0:1407] ks, input logic ordy,
                        output logic [127:0] ct, output int lat, output bit timeout);
        int n;
        int acc;
        @(negedge clk);
        if4.plainText = pt;
        if4.keys      = ks;
        if4.out_ready = ordy;
        if4.in_valid  = 1'b1;
        n = 0;
        while (!if4.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        @(negedge clk);
        if4.in_valid = 1'b0;
        n = 0;
        while (!if4.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        timeout = !if4.out_valid;
        lat     = cyc - acc;
        ct      = if4.encryptedText;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (if4.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", if4.in_ready); end
        checks++; if (if4.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", if4.out_valid); end
        checks++; if (busy4 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy4); end
        checks++; if (ri4 !== 4'd0) begin fails++; $display("FAIL reset_round_idx: got %0d expected 0", ri4); end
        checks++; if (if4.encryptedText !== 128'h0) begin fails++; $display("FAIL reset_ct: got %h expected 0", if4.encryptedText); end
        $display("test_reset done");
    endtask

    task automatic test_vector1();
        int acc;
        int n;
        @(negedge clk);
        if4.plainText = PT1;
        if4.keys      = ks4_1;
        if4.out_ready = 1'b1;
        if4.in_valid  = 1'b1;
        acc = cyc;
        checks++; if (if4.in_ready !== 1'b1) begin fails++; $display("FAIL v1_in_ready: got %b expected 1", if4.in_ready); end
        @(negedge clk);
        if4.in_valid = 1'b0;
        checks++; if (ri4 !== 4'd1) begin fails++; $display("FAIL v1_first_round_idx: got %0d expected 1", ri4); end
        checks++; if (busy4 !== 1'b1) begin fails++; $display("FAIL v1_busy: got %b expected 1", busy4); end
        n = 0;
        while (!if4.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (if4.out_valid !== 1'b1) begin fails++; $display("FAIL v1_timeout: out_valid got %b expected 1", if4.out_valid); end
        checks++; if (cyc - acc !== 11) begin fails++; $display("FAIL v1_latency: got %0d expected 11", cyc - acc); end
        checks++; if (if4.encryptedText !== CT1) begin fails++; $display("FAIL v1_ct: got %h expected %h", if4.encryptedText, CT1); end
        checks++; if (busy4 !== 1'b0) begin fails++; $display("FAIL v1_busy_done: got %b expected 0", busy4); end
        $display("test_vector1: ct=%h latency=%0d", if4.encryptedText, cyc - acc);
    endtask

    task automatic test_back_pressure();
        logic [127:0] ct;
        int           lat;
        bit           to;
        run4(PT2, ks4_2, 1'b0, ct, lat, to);
        checks++; if (to) begin fails++; $display("FAIL bp_timeout: out_valid got 0 expected 1"); end
        checks++; if (ct !== CT2) begin fails++; $display("FAIL bp_ct: got %h expected %h", ct, CT2); end
        checks++; if (lat !== 11) begin fails++; $display("FAIL bp_latency: got %0d expected 11", lat); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (if4.encryptedText !== CT2 || if4.out_valid !== 1'b1 || if4.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got ct=%h ov=%b ir=%b expected ct=%h ov=1 ir=0",
                         i, if4.encryptedText, if4.out_valid, if4.in_ready, CT2);
            end
        end
        if4.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (if4.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_ov: got %b expected 0", if4.out_valid); end
        checks++; if (if4.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ir: got %b expected 1", if4.in_ready); end
        checks++; if (ri4 !== 4'd0) begin fails++; $display("FAIL bp_release_ri: got %0d expected 0", ri4); end
        $display("test_back_pressure: ct=%h held 20 cycles", ct);
    endtask

    task automatic test_aes192();
        int acc;
        int n;
        @(negedge clk);
        if6.plainText = PT1;
        if6.keys      = ks6;
        if6.out_ready = 1'b1;
        if6.in_valid  = 1'b1;
        acc = cyc;
        @(negedge clk);
        if6.in_valid = 1'b0;
        checks++; if (busy6 !== 1'b1) begin fails++; $display("FAIL aes192_busy: got %b expected 1", busy6); end
        n = 0;
        while (!if6.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (if6.out_valid !== 1'b1) begin fails++; $display("FAIL aes192_timeout: out_valid got 0 expected 1"); end
        checks++; if (cyc - acc !== 13) begin fails++; $display("FAIL aes192_latency: got %0d expected 13", cyc - acc); end
        checks++; if (if6.encryptedText !== CT192) begin fails++; $display("FAIL aes192_ct: got %h expected %h", if6.encryptedText, CT192); end
        checks++; if (ri6 !== 4'd12) begin fails++; $display("FAIL aes192_round_idx: got %0d expected 12", ri6); end
        $display("test_aes192: ct=%h latency=%0d", if6.encryptedText, cyc - acc);
    endtask

    task automatic test_aes256();
        int acc;
        int n;
        @(negedge clk);
        if8.plainText = PT1;
        if8.keys      = ks8;
        if8.out_ready = 1'b1;
        if8.in_valid  = 1'b1;
        acc = cyc;
        @(negedge clk);
        if8.in_valid = 1'b0;
        checks++; if (busy8 !== 1'b1) begin fails++; $display("FAIL aes256_busy: got %b expected 1", busy8); end
        n = 0;
        while (!if8.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (if8.out_valid !== 1'b1) begin fails++; $display("FAIL aes256_timeout: out_valid got 0 expected 1"); end
        checks++; if (cyc - acc !== 15) begin fails++; $display("FAIL aes256_latency: got %0d expected 15", cyc - acc); end
        checks++; if (if8.encryptedText !== CT256) begin fails++; $display("FAIL aes256_ct: got %h expected %h", if8.encryptedText, CT256); end
        checks++; if (ri8 !== 4'd14) begin fails++; $display("FAIL aes256_round_idx: got %0d expected 14", ri8); end
        $display("test_aes256: ct=%h latency=%0d", if8.encryptedText, cyc - acc);
    endtask

    task automatic test_clear();
        int           n;
        bit           seen_ov;
        logic [127:0] ct;
        int           lat;
        bit           to;
        @(negedge clk);
        if4.plainText = PT1;
        if4.keys      = ks4_1;
        if4.out_ready = 1'b1;
        if4.in_valid  = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        n = 0;
        while (ri4 !== 4'd5 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (ri4 !== 4'd5) begin fails++; $display("FAIL clear_reach_r5: got %0d expected 5", ri4); end
        clear4 = 1'b1;
        @(negedge clk);
        clear4 = 1'b0;
        checks++; if (if4.out_valid !== 1'b0) begin fails++; $display("FAIL clear_ov: got %b expected 0", if4.out_valid); end
        checks++; if (if4.in_ready !== 1'b1) begin fails++; $display("FAIL clear_ir: got %b expected 1", if4.in_ready); end
        checks++; if (busy4 !== 1'b0) begin fails++; $display("FAIL clear_busy: got %b expected 0", busy4); end
        checks++; if (ri4 !== 4'd0) begin fails++; $display("FAIL clear_ri: got %0d expected 0", ri4); end
        checks++; if (if4.encryptedText !== CT2) begin fails++; $display("FAIL clear_ct_kept: got %h expected %h", if4.encryptedText, CT2); end
        seen_ov = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (if4.out_valid) seen_ov = 1'b1;
        end
        checks++; if (seen_ov) begin fails++; $display("FAIL clear_no_output: got out_valid 1 expected 0"); end
        // clear together with in_valid in IDLE: nothing is accepted
        clear4        = 1'b1;
        if4.in_valid  = 1'b1;
        @(negedge clk);
        clear4       = 1'b0;
        if4.in_valid = 1'b0;
        checks++; if (busy4 !== 1'b0 || if4.in_ready !== 1'b1) begin
            fails++; $display("FAIL clear_vs_valid: got busy=%b ir=%b expected busy=0 ir=1", busy4, if4.in_ready);
        end
        run4(PT1, ks4_1, 1'b1, ct, lat, to);
        checks++; if (to || ct !== CT1 || lat !== 11) begin
            fails++; $display("FAIL clear_after_block: got ct=%h lat=%0d to=%b expected ct=%h lat=11", ct, lat, to, CT1);
        end
        $display("test_clear: post-clear ct=%h", ct);
    endtask

    task automatic test_reset_mid();
        bit           seen_ov;
        logic [127:0] ct;
        int           lat;
        bit           to;
        @(negedge clk);
        if4.plainText = PT2;
        if4.keys      = ks4_2;
        if4.out_ready = 1'b1;
        if4.in_valid  = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (ri4 !== 4'd0 || busy4 !== 1'b0) begin
            fails++; $display("FAIL rst_mid_fsm: got ri=%0d busy=%b expected ri=0 busy=0", ri4, busy4);
        end
        checks++; if (if4.in_ready !== 1'b1 || if4.out_valid !== 1'b0) begin
            fails++; $display("FAIL rst_mid_hs: got ir=%b ov=%b expected ir=1 ov=0", if4.in_ready, if4.out_valid);
        end
        checks++; if (if4.encryptedText !== 128'h0) begin fails++; $display("FAIL rst_mid_ct: got %h expected 0", if4.encryptedText); end
        @(negedge clk);
        reset = 1'b0;
        seen_ov = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (if4.out_valid) seen_ov = 1'b1;
        end
        checks++; if (seen_ov) begin fails++; $display("FAIL rst_mid_no_output: got out_valid 1 expected 0"); end
        run4(PT1, ks4_1, 1'b1, ct, lat, to);
        checks++; if (to || ct !== CT1 || lat !== 11) begin
            fails++; $display("FAIL rst_mid_after_block: got ct=%h lat=%0d to=%b expected ct=%h lat=11", ct, lat, to, CT1);
        end
        $display("test_reset_mid: post-reset ct=%h", ct);
    endtask

    task automatic test_back_to_back();
        logic [127:0]  pts [3];
        logic [0:1407] kss [3];
        logic [127:0]  exps [3];
        int            acc_cyc [3];
        int            na;
        int            no;
        int            n;
        pts[0] = PT1;   kss[0] = ks4_1; exps[0] = CT1;
        pts[1] = PT2;   kss[1] = ks4_2; exps[1] = CT2;
        pts[2] = PT1;   kss[2] = ks4_1; exps[2] = CT1;
        na = 0; no = 0; n = 0;
        @(negedge clk);
        if4.plainText = pts[0];
        if4.keys      = kss[0];
        if4.out_ready = 1'b1;
        if4.in_valid  = 1'b1;
        while (no < 3 && n < 200) begin
            if (if4.in_valid && if4.in_ready && na < 3) begin
                acc_cyc[na] = cyc;
                na++;
            end
            if (if4.out_valid) begin
                checks++;
                if (if4.encryptedText !== exps[no]) begin
                    fails++; $display("FAIL b2b_ct[%0d]: got %h expected %h", no, if4.encryptedText, exps[no]);
                end
                $display("test_back_to_back: block %0d ct=%h", no, if4.encryptedText);
                no++;
                if (no < 3) begin
                    if4.plainText = pts[no];
                    if4.keys      = kss[no];
                end else begin
                    if4.in_valid = 1'b0;
                end
            end
            @(negedge clk);
            n++;
        end
        if4.in_valid = 1'b0;
        checks++; if (no !== 3) begin fails++; $display("FAIL b2b_outputs: got %0d expected 3", no); end
        checks++; if (na !== 3) begin fails++; $display("FAIL b2b_accepts: got %0d expected 3", na); end
        if (na == 3) begin
            checks++; if (acc_cyc[1] - acc_cyc[0] !== 12) begin fails++; $display("FAIL b2b_gap01: got %0d expected 12", acc_cyc[1] - acc_cyc[0]); end
            checks++; if (acc_cyc[2] - acc_cyc[1] !== 12) begin fails++; $display("FAIL b2b_gap12: got %0d expected 12", acc_cyc[2] - acc_cyc[1]); end
        end
    endtask

`ifdef AES_ITER_KEY_LATCH_EN
    task automatic test_key_latch();
        logic [0:1407] junk;
        int            n;
        @(negedge clk);
        if4.plainText = PT1;
        if4.keys      = ks4_1;
        if4.out_ready = 1'b1;
        if4.in_valid  = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        for (int i = 0; i < 44; i++) junk[32*i +: 32] = $urandom();
        if4.keys      = junk;
        if4.plainText = {$urandom(), $urandom(), $urandom(), $urandom()};
        n = 0;
        while (!if4.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (if4.out_valid !== 1'b1 || if4.encryptedText !== CT1) begin
            fails++; $display("FAIL key_latch_ct: got ov=%b ct=%h expected ov=1 ct=%h", if4.out_valid, if4.encryptedText, CT1);
        end
        $display("test_key_latch: ct=%h", if4.encryptedText);
    endtask
`endif

    initial begin
        logic [0:1919] tmp;
        reset  = 1'b1;
        clear4 = 1'b0; clear6 = 1'b0; clear8 = 1'b0;
        if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.plainText = '0; if4.keys = '0;
        if6.in_valid = 1'b0; if6.out_ready = 1'b0; if6.plainText = '0; if6.keys = '0;
        if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.plainText = '0; if8.keys = '0;
        tmp   = expand(4, KEY1);   ks4_1 = tmp[0:1407];
        tmp   = expand(4, KEY2);   ks4_2 = tmp[0:1407];
        tmp   = expand(6, KEY192); ks6   = tmp[0:1663];
        ks8   = expand(8, KEY256);

        test_reset();
        test_vector1();
        test_back_pressure();
        test_aes192();
        test_aes256();
        test_clear();
        test_reset_mid();
        test_back_to_back();
`ifdef AES_ITER_KEY_LATCH_EN
        test_key_latch();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
